bpsk_demod: RTL

Coherent BPSK demodulator that closes the loop opposite the carrier generator. It multiplies each received signed sample by the locally generated signed carrier, integrates the products over one symbol, and at the symbol boundary decides the bit from the sign of the correlation. It sits at the receive end of the BPSK chain, fed by the receive sample path and by a carrier generator instance that is phase-aligned to it.

---
 rtl/bpsk_demod.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bpsk_demod.sv
// bpsk_demod: coherent BPSK demodulator.
//
// Multiplies each accepted received sample by the local carrier, integrates the
// products over one symbol and decides the bit from the sign of the correlation.
// Two-stage pipeline:
//   stage 1 registers the full-width product with valid and last-of-symbol flags;
//   stage 2 accumulates it and makes the decision on the last product.
//
// Ports:
//   clk_sig        in   sample clock
//   rst_n          in   asynchronous active-low reset
//   en_sig         in   sample strobe; rx_sig, carrier_sig and sync_sig sampled when high
//   rx_sig         in   received sample, signed SAMPLE_W
//   carrier_sig    in   local reference carrier, signed SAMPLE_W
//   sync_sig       in   first sample of a symbol (qualified by en_sig)
//   bit_sig        out  decided bit (1 when correlation >= 0)
//   bit_valid_sig  out  one-cycle pulse when bit_sig/metric_sig are updated
//   metric_sig     out  signed correlation of the last completed symbol
//   lock_sig       out  lock indication
//
// Optional feature: define BPSK_DEMOD_LOCK_DET_EN to build the lock detector;
// otherwise lock_sig is tied to 0.

module bpsk_demod #(
  parameter int     SAMPLE_W      = 16,
  parameter int     SAMPS_PER_SYM = 256,
  parameter int     ACC_W         = 2 * SAMPLE_W + $clog2(SAMPS_PER_SYM),
  parameter longint LOCK_THRESH   = 64'sd1 << 30,
  parameter int     LOCK_CNT      = 8
) (
  input  logic                       clk_sig,
  input  logic                       rst_n,
  input  logic                       en_sig,
  input  logic signed [SAMPLE_W-1:0] rx_sig,
  input  logic signed [SAMPLE_W-1:0] carrier_sig,
  input  logic                       sync_sig,
  output logic                       bit_sig,
  output logic                       bit_valid_sig,
  output logic signed [ACC_W-1:0]    metric_sig,
  output logic                       lock_sig
);

  localparam int IdxW  = $clog2(SAMPS_PER_SYM);
  localparam int ProdW = 2 * SAMPLE_W;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic signed [ProdW-1:0]  prod_q;
  logic                     prod_valid_q;
  logic                     prod_last_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     bit_q;
  logic                     bit_valid_q;
  logic signed [ACC_W-1:0]  metric_q;

  logic                     start;
  logic                     accept;
  logic                     resync;
  logic                     last_d;
  logic                     decide;
  logic signed [ProdW-1:0]  prod_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;

  always_comb begin
    start    = en_sig && sync_sig;
    accept   = en_sig && (sync_sig || (state_q == StRun));
    // A sync while running aborts the partial symbol, including any product in stage 1.
    resync   = start && (state_q == StRun);
    // A sync sample is always index 0, so it can never close a symbol.
    last_d   = !start && (idx_q == IdxW'(SAMPS_PER_SYM - 1));
    prod_d   = rx_sig * carrier_sig;
    prod_ext = {{(ACC_W - ProdW){prod_q[ProdW-1]}}, prod_q};
    sum      = acc_q + prod_ext;
    decide   = !resync && prod_valid_q && prod_last_q;
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_q        <= '0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      metric_q     <= '0;
    end else begin
      bit_valid_q <= 1'b0;
      if (start) begin
        state_q <= StRun;
      end

      // Stage 1: valid only follows accepted samples, so en_sig low drains it.
      prod_valid_q <= accept;
      if (accept) begin
        prod_q      <= prod_d;
        prod_last_q <= last_d;
        idx_q       <= start ? IdxW'(1) : idx_q + IdxW'(1);
      end

      // Stage 2
      if (resync) begin
        acc_q <= '0;
      end else if (prod_valid_q) begin
        if (prod_last_q) begin
          metric_q    <= sum;
          bit_q       <= ~sum[ACC_W-1];
          bit_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

  assign bit_sig       = bit_q;
  assign bit_valid_sig = bit_valid_q;
  assign metric_sig    = metric_q;

`ifdef BPSK_DEMOD_LOCK_DET_EN
  localparam int                 CntW    = $clog2(LOCK_CNT + 1);
  localparam logic [ACC_W-1:0]   LockThr = ACC_W'(LOCK_THRESH);

  logic [CntW-1:0]  good_cnt_q;
  logic [CntW-1:0]  good_cnt_d;
  logic [ACC_W-1:0] sum_mag;
  logic             good;
  logic             lock_q;

  always_comb begin
    // Unsigned magnitude: the most negative sum still maps to its true magnitude.
    sum_mag    = sum[ACC_W-1] ? $unsigned(-sum) : $unsigned(sum);
    good       = sum_mag >= LockThr;
    good_cnt_d = (good_cnt_q == CntW'(LOCK_CNT)) ? good_cnt_q : good_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else if (decide) begin
      if (good) begin
        good_cnt_q <= good_cnt_d;
        lock_q     <= (good_cnt_d == CntW'(LOCK_CNT));
      end else begin
        good_cnt_q <= '0;
        lock_q     <= 1'b0;
      end
    end
  end

  assign lock_sig = lock_q;
`else
  logic unused_decide;
  assign unused_decide = decide;
  assign lock_sig      = 1'b0;
`endif

endmodule
